// File: rtl/wbr_pkg.sv
// Shared definitions for the input-side wrapper boundary register.
// Provides the 2-bit wrapper mode type and its four encodings.
package wbr_pkg;

  typedef logic [1:0] wbr_mode_t;

  localparam wbr_mode_t WBR_FUNC   = 2'b00;
  localparam wbr_mode_t WBR_INTEST = 2'b01;
  localparam wbr_mode_t WBR_EXTEST = 2'b10;
  localparam wbr_mode_t WBR_BYPASS = 2'b11;

endpackage

// File: rtl/wbr_cell.sv
// One boundary-register cell: a shift flop and an update flop.
// Ports:
//   CLK, resetn  clock, async active-low reset
//   i_si         serial input from the upstream cell (or wsi)
//   i_cap_d      functional value captured on i_capture
//   i_shift      shift this cycle (has priority over capture)
//   i_capture    capture i_cap_d into the shift flop
//   i_update     copy the shift flop into the update flop
//   o_so         shift flop output (serial toward the next cell)
//   o_upd        update flop output
module wbr_cell (
  input  logic CLK,
  input  logic resetn,
  input  logic i_si,
  input  logic i_cap_d,
  input  logic i_shift,
  input  logic i_capture,
  input  logic i_update,
  output logic o_so,
  output logic o_upd
);

  logic r_sh;
  logic r_upd;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)        r_sh <= 1'b0;
    else if (i_shift)   r_sh <= i_si;
    else if (i_capture) r_sh <= i_cap_d;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)       r_upd <= 1'b0;
    else if (i_update) r_upd <= r_sh;
  end

  assign o_so  = r_sh;
  assign o_upd = r_upd;

endmodule

// File: rtl/wbr_input_chain.sv
// Input-side wrapper boundary register: WIDTH data cells plus one ready
// cell (chain length L = WIDTH+1), a bypass flop, a scan-load counter and
// the core-side mode mux.
// Ports:
//   CLK, resetn       clock, async active-low reset
//   wsi / wso         wrapper serial in / out
//   din, ready_in     functional inputs from chip pins
//   wse, wce, wue     shift / capture / update enables
//   hold_inputs       in EXTEST, drive safe values into the core
//   mode              00 FUNC, 01 INTEST, 10 EXTEST, 11 BYPASS
//   core_din, core_ready  values driven into the core
//   shift_done        1-cycle pulse after L consecutive chain shifts
module wbr_input_chain
  import wbr_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] SAFE_VAL = '0,
  parameter logic            SAFE_RDY = 1'b0
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             wsi,
  input  logic [WIDTH-1:0] din,
  input  logic             ready_in,
  input  logic             wse,
  input  logic             wce,
  input  logic             wue,
  input  logic             hold_inputs,
  input  wbr_mode_t        mode,
  output logic [WIDTH-1:0] core_din,
  output logic             core_ready,
  output logic             wso,
  output logic             shift_done
);

  localparam int L  = WIDTH + 1;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  logic         w_byp_mode;
  logic         w_chain_shift;
  logic         w_cap;
  logic         w_upd;
  logic [L-1:0] w_sh;
  logic [L-1:0] w_si;
  logic [L-1:0] w_cap_d;
  logic [L-1:0] w_upd_q;

  logic          r_byp;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  wbr_mode_t     r_mode_q;

  // Bypass freezes the chain entirely; shift outranks capture and update.
  assign w_byp_mode    = (mode == WBR_BYPASS);
  assign w_chain_shift = wse & ~w_byp_mode;
  assign w_cap         = wce & ~wse & ~w_byp_mode;
  assign w_upd         = wue & ~wse & ~w_byp_mode;

  // Chain shifts toward index 0; wsi enters the ready cell at the top.
  assign w_si    = {wsi, w_sh[L-1:1]};
  assign w_cap_d = {ready_in, din};

  for (genvar i = 0; i < L; i++) begin : g_cell
    wbr_cell u_cell (
      .CLK       (CLK),
      .resetn    (resetn),
      .i_si      (w_si[i]),
      .i_cap_d   (w_cap_d[i]),
      .i_shift   (w_chain_shift),
      .i_capture (w_cap),
      .i_update  (w_upd),
      .o_so      (w_sh[i]),
      .o_upd     (w_upd_q[i])
    );
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)                 r_byp <= 1'b0;
    else if (wse && w_byp_mode)  r_byp <= wsi;
  end

  // Previous-cycle mode, used only to detect mode changes. Left out of
  // reset so that a reset pulse mid-load does not look like a mode change
  // and swallow the first shift after release.
  always_ff @(posedge CLK) r_mode_q <= mode;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_chain_shift || (mode != r_mode_q)) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign shift_done = r_done;
  assign wso        = w_byp_mode ? r_byp : w_sh[0];

  always_comb begin
    core_din   = din;
    core_ready = ready_in;
    case (mode)
      WBR_INTEST: {core_ready, core_din} = w_upd_q;
      WBR_EXTEST: begin
        if (hold_inputs) begin
          core_din   = SAFE_VAL;
          core_ready = SAFE_RDY;
        end
      end
      default: ;
    endcase
  end

endmodule
